// File: rtl/kalman_predict_unit.sv
// -----------------------------------------------------------------------------
// kalman_predict_unit
//   Time-update (predict) stage of the 6-state constant-velocity tracker.
//   State X = [px py pz vx vy vz], F = [I dt*I; 0 I].
//     Xp = F*X
//     Pp = F*P*F^T + diag(q_pos x3, q_vel x3)
//   The 36 covariance entries are produced one per clock. Each entry is
//   computed directly from the captured P, so no symmetry is assumed.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts any operation)
//   start   request, sampled only while idle
//   dt      time step, signed Q(W-FRAC).FRAC
//   q_pos   process noise for the three position diagonal entries
//   q_vel   process noise for the three velocity diagonal entries
//   x_in    state vector, element i at [W*i +: W]
//   p_in    covariance, row-major, entry (i,j) at [W*(6*i+j) +: W]
//   busy    high while loading and computing
//   done    one-cycle pulse, xp_out/pp_out complete
//   xp_out  predicted state, same packing as x_in
//   pp_out  predicted covariance, same packing as p_in
// -----------------------------------------------------------------------------
module kalman_predict_unit #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    dt,
    input  logic [W-1:0]    q_pos,
    input  logic [W-1:0]    q_vel,
    input  logic [6*W-1:0]  x_in,
    input  logic [36*W-1:0] p_in,
    output logic            busy,
    output logic            done,
    output logic [6*W-1:0]  xp_out,
    output logic [36*W-1:0] pp_out
);

    // Accumulator carries 4 guard bits so up to five W-bit-scale terms can be
    // summed before the final saturation back to W bits.
    localparam int AW = W + 4;

    typedef logic signed [W-1:0]   word_t;
    typedef logic signed [AW-1:0]  acc_t;
    typedef logic signed [2*W-1:0] prod_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam acc_t  ACC_MAX = acc_t'((2 ** (W - 1)) - 1);
    localparam acc_t  ACC_MIN = -acc_t'(2 ** (W - 1));
    localparam prod_t SQ_MAX  = prod_t'((2 ** (W - 1)) - 1);

    // Full-precision signed product, floor-scaled back by FRAC, kept at AW bits.
    function automatic acc_t mul_shift(input word_t a, input word_t b);
        prod_t prod;
        prod = a * b;
        return acc_t'(prod >>> FRAC);
    endfunction

    function automatic acc_t ext(input word_t v);
        return acc_t'(v);
    endfunction

    function automatic word_t saturate(input acc_t v);
        if (v > ACC_MAX) begin
            return word_t'(ACC_MAX);
        end else if (v < ACC_MIN) begin
            return word_t'(ACC_MIN);
        end else begin
            return word_t'(v);
        end
    endfunction

    state_t      state, state_nxt;
    logic [5:0]  idx;
    logic [2:0]  row, col;

    word_t       x_r [6];
    word_t       p_r [36];
    word_t       dt_r, dt2_r, qp_r, qv_r;

    prod_t       dt_sq;
    word_t       dt2_nxt;
    acc_t        pp_acc, xp_acc;
    word_t       pp_entry, xp_entry;

    // ------------------------------------------------------------------
    // Control FSM: next state and status outputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == 6'd35) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // dt^2 scaled back to Q format; dt*dt is never negative, so only the
    // upper bound needs clamping.
    always_comb begin
        dt_sq   = word_t'(dt) * word_t'(dt);
        dt_sq   = dt_sq >>> FRAC;
        dt2_nxt = (dt_sq > SQ_MAX) ? word_t'(SQ_MAX) : word_t'(dt_sq);
    end

    // ------------------------------------------------------------------
    // Datapath for the entry selected by idx (row = idx/6, col = idx%6).
    // Index offsets: (row+3,col) = idx+18, (row,col+3) = idx+3,
    // (row+3,col+3) = idx+21; each is only read when it exists.
    // ------------------------------------------------------------------
    always_comb begin
        pp_acc = ext(p_r[idx]);
        if (row < 3'd3) pp_acc = pp_acc + mul_shift(dt_r, p_r[idx + 6'd18]);
        if (col < 3'd3) pp_acc = pp_acc + mul_shift(dt_r, p_r[idx + 6'd3]);
        if (row < 3'd3 && col < 3'd3) pp_acc = pp_acc + mul_shift(dt2_r, p_r[idx + 6'd21]);
        if (row == col) pp_acc = pp_acc + ext((row < 3'd3) ? qp_r : qv_r);
        pp_entry = saturate(pp_acc);

        xp_acc = '0;
        if (idx < 6'd6) begin
            xp_acc = ext(x_r[idx[2:0]]);
            if (idx < 6'd3) xp_acc = xp_acc + mul_shift(dt_r, x_r[idx[2:0] + 3'd3]);
        end
        xp_entry = saturate(xp_acc);
    end

    // ------------------------------------------------------------------
    // State, capture registers and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            row    <= '0;
            col    <= '0;
            dt_r   <= '0;
            dt2_r  <= '0;
            qp_r   <= '0;
            qv_r   <= '0;
            xp_out <= '0;
            pp_out <= '0;
            // NOTE: the captured operand arrays are cleared too, so a
            // reset leaves no stale values from an aborted operation.
            for (int n = 0; n < 6; n++)  x_r[n] <= '0;
            for (int n = 0; n < 36; n++) p_r[n] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
            unique case (state)
                S_LOAD: begin
                    dt_r  <= word_t'(dt);
                    dt2_r <= dt2_nxt;
                    qp_r  <= word_t'(q_pos);
                    qv_r  <= word_t'(q_vel);
                    for (int n = 0; n < 6; n++)  x_r[n] <= word_t'(x_in[W*n +: W]);
                    for (int n = 0; n < 36; n++) p_r[n] <= word_t'(p_in[W*n +: W]);
                    idx <= '0;
                    row <= '0;
                    col <= '0;
                end
                S_RUN: begin
                    pp_out[W*idx +: W] <= pp_entry;
                    if (idx < 6'd6) xp_out[W*idx +: W] <= xp_entry;
                    idx <= idx + 6'd1;
                    if (col == 3'd5) begin
                        col <= '0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_kalman_predict_unit
//   Self-checking bench for kalman_predict_unit. A behavioural model evaluates
//   Xp = F*X and Pp = F*P*F^T + Q with wide integer arithmetic and saturation;
//   a compare process checks the outputs whenever done pulses. Directed cases
//   pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_kalman_predict_unit;

    localparam int W    = 16;
    localparam int FRAC = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    dt, q_pos, q_vel;
    logic [6*W-1:0]  x_in;
    logic [36*W-1:0] p_in;
    logic            busy, done;
    logic [6*W-1:0]  xp_out;
    logic [36*W-1:0] pp_out;

    int vec;
    int miscomp;
    bit armed;

    logic [6*W-1:0]  exp_xp;
    logic [36*W-1:0] exp_pp;

    kalman_predict_unit #(.W(W), .FRAC(FRAC)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dt     (dt),
        .q_pos  (q_pos),
        .q_vel  (q_vel),
        .x_in   (x_in),
        .p_in   (p_in),
        .busy   (busy),
        .done   (done),
        .xp_out (xp_out),
        .pp_out (pp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [36*W-1:0] act, input logic [36*W-1:0] exp);
        vec++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint mulsh(input longint a, input longint b);
        return (a * b) >>> FRAC;
    endfunction

    function automatic logic [W-1:0] sat(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic longint pe(input int i, input int j);
        return sx(p_in[W*(6*i+j) +: W]);
    endfunction

    function automatic void compute_model();
        longint d, d2, s;
        d  = sx(dt);
        d2 = mulsh(d, d);
        if (d2 > 32767) d2 = 32767;
        for (int i = 0; i < 6; i++) begin
            s = sx(x_in[W*i +: W]);
            if (i < 3) s += mulsh(d, sx(x_in[W*(i+3) +: W]));
            exp_xp[W*i +: W] = sat(s);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                s = pe(i, j);
                if (i < 3) s += mulsh(d, pe(i+3, j));
                if (j < 3) s += mulsh(d, pe(i, j+3));
                if (i < 3 && j < 3) s += mulsh(d2, pe(i+3, j+3));
                if (i == j) s += (i < 3) ? sx(q_pos) : sx(q_vel);
                exp_pp[W*(6*i+j) +: W] = sat(s);
            end
        end
    endfunction

    function automatic logic [W-1:0] pp_at(input int i, input int j);
        return pp_out[W*(6*i+j) +: W];
    endfunction

    // ---------------- stimulus helpers ----------------
    // dt limited to +/-2.0 keeps every intermediate sum inside the DUT's
    // guard range while still driving the final result into saturation.
    task automatic rand_inputs();
        dt    = 16'($urandom_range(0, 1024) - 512);
        q_pos = 16'($urandom);
        q_vel = 16'($urandom);
        for (int n = 0; n < 6; n++)  x_in[W*n +: W] = 16'($urandom);
        for (int n = 0; n < 36; n++) p_in[W*n +: W] = 16'($urandom);
    endtask

    task automatic clear_inputs();
        dt = '0; q_pos = '0; q_vel = '0; x_in = '0; p_in = '0;
    endtask

    task automatic set_p(input int i, input int j, input logic [W-1:0] v);
        p_in[W*(6*i+j) +: W] = v;
    endtask

    // Start an operation and follow it to done (or to an injected reset).
    task automatic run_op(input string tag, input int repulse_at, input int rst_at, input bit scramble);
        int cycles;
        @(posedge clk); #1;
        start = 1'b1;
        compute_model();
        armed = (rst_at == 0);
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        check({tag, "_busy_load"}, 576'(busy), 576'(1));
        while (cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (scramble && cycles == 3) rand_inputs();
            start = (cycles == repulse_at);
            if (rst_at != 0 && cycles == rst_at) begin
                armed = 1'b0;
                rst   = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check({tag, "_abort_busy"}, 576'(busy), 576'(0));
                check({tag, "_abort_done"}, 576'(done), 576'(0));
                check({tag, "_abort_xp"},   576'(xp_out), 576'(0));
                check({tag, "_abort_pp"},   pp_out, 576'(0));
                repeat (45) @(posedge clk);
                return;
            end
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 576'(cycles), 576'(38));
        check({tag, "_busy_at_done"}, 576'(busy), 576'(0));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_xp"}, 576'(xp_out), 576'(exp_xp));
        check({tag, "_hold_pp"}, pp_out, exp_pp);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (!armed) begin
                check("done_unexpected", 576'(done), 576'(0));
            end else begin
                check("xp_at_done", 576'(xp_out), 576'(exp_xp));
                check("pp_at_done", pp_out, exp_pp);
                armed = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec = 0; miscomp = 0; armed = 1'b0;
        rst = 1'b1; start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 576'(busy), 576'(0));
        check("reset_done", 576'(done), 576'(0));
        check("reset_xp",   576'(xp_out), 576'(0));
        check("reset_pp",   pp_out, 576'(0));
        rst = 1'b0;

        // 1: dt=0, q=0 -> identity on both X and P.
        rand_inputs();
        dt = '0; q_pos = '0; q_vel = '0;
        run_op("t1", 0, 0, 1'b0);
        check("t1_xp_eq_x", 576'(xp_out), 576'(x_in));
        check("t1_pp_eq_p", pp_out, p_in);

        // 2: position advanced by dt*velocity.
        clear_inputs();
        dt   = 16'h0100;
        x_in = {16'h0080, 16'h0080, 16'h0080, 16'h0300, 16'h0200, 16'h0100};
        run_op("t2", 0, 0, 1'b0);
        check("t2_xp", 576'(xp_out), 576'({16'h0080, 16'h0080, 16'h0080, 16'h0380, 16'h0280, 16'h0180}));

        // 3: P = I, dt = 1.0.
        clear_inputs();
        dt = 16'h0100;
        for (int n = 0; n < 6; n++) set_p(n, n, 16'h0100);
        run_op("t3", 0, 0, 1'b0);
        check("t3_pp00", 576'(pp_at(0, 0)), 576'(16'h0200));
        check("t3_pp03", 576'(pp_at(0, 3)), 576'(16'h0100));
        check("t3_pp30", 576'(pp_at(3, 0)), 576'(16'h0100));
        check("t3_pp33", 576'(pp_at(3, 3)), 576'(16'h0100));
        check("t3_pp01", 576'(pp_at(0, 1)), 576'(16'h0000));

        // 4: only process noise.
        clear_inputs();
        q_pos = 16'h0010; q_vel = 16'h0020;
        run_op("t4", 0, 0, 1'b0);
        check("t4_pp11", 576'(pp_at(1, 1)), 576'(16'h0010));
        check("t4_pp55", 576'(pp_at(5, 5)), 576'(16'h0020));
        check("t4_pp24", 576'(pp_at(2, 4)), 576'(16'h0000));

        // 5: saturation high, then low.
        clear_inputs();
        dt = 16'h0100;
        set_p(0, 0, 16'h7F00); set_p(0, 3, 16'h7F00); set_p(3, 0, 16'h7F00); set_p(3, 3, 16'h7F00);
        run_op("t5a", 0, 0, 1'b0);
        check("t5_sat_hi", 576'(pp_at(0, 0)), 576'(16'h7FFF));
        set_p(0, 0, 16'h8100); set_p(0, 3, 16'h8100); set_p(3, 0, 16'h8100); set_p(3, 3, 16'h8100);
        run_op("t5b", 0, 0, 1'b0);
        check("t5_sat_lo", 576'(pp_at(0, 0)), 576'(16'h8000));

        // 6: start re-pulsed mid-run with inputs changing, then reset abort,
        //    then a normal run.
        rand_inputs();
        run_op("t6a", 10, 0, 1'b1);
        rand_inputs();
        run_op("t6b", 0, 20, 1'b0);
        rand_inputs();
        run_op("t6c", 0, 0, 1'b0);

        // Random regression.
        for (int r = 0; r < 8; r++) begin
            rand_inputs();
            run_op("rand", (r % 2 == 0) ? 15 : 0, 0, r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule
